// File: rtl/ram_loader_pkg.sv
// Shared definitions for the boot loader and the CPU it feeds: loader FSM encoding, frame marker, opcodes.
package ram_loader_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SYNC  = 3'd1;
    localparam logic [2:0] ST_LEN   = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_CHECK = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_ERROR = 3'd6;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDI = 4'h1,
        OP_LD  = 4'h2,
        OP_ST  = 4'h3,
        OP_ADD = 4'h4,
        OP_JMP = 4'h8,
        OP_HLT = 4'hF
    } cpu_op_e;

    function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/ram_loader_if.sv
// Byte stream in and RAM write port out of the program loader.
interface ram_loader_if #(
    parameter int ADDR_W = 4
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/ram_loader.sv
// Loads a SYNC/LEN/data/CHK framed program image into RAM while holding the CPU in reset.
// Latency: a data byte accepted in cycle N is written to RAM in cycle N+1.
// Backpressure: rx_ready high only while parsing a frame; stalls indefinitely on rx_valid low.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int         ADDR_W    = 4,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    ram_loader_if.slave    bus,
    output logic           cpu_hold,
    output logic           load_done,
    output logic           load_error
);

    localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_L   = {{ADDR_W{1'b0}}, 1'b1};

    logic [2:0]        state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [7:0]        sum_q, sum_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d;

    logic              rx_ready;
    logic              xfer;
    logic              len_too_big;
    logic [ADDR_W:0]   len_dec;

    assign rx_ready = (state_q == ST_SYNC) || (state_q == ST_LEN) ||
                      (state_q == ST_DATA) || (state_q == ST_CHECK);
    assign xfer     = bus.rx_valid && rx_ready;

    // LEN = 0 encodes a full-depth image; anything beyond the RAM depth is rejected.
    assign len_too_big = (32'(bus.rx_data) > (32'd1 << ADDR_W));
    assign len_dec     = (bus.rx_data == 8'd0) ? DEPTH_L : (ADDR_W+1)'(bus.rx_data);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        sum_d       = sum_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (xfer && (bus.rx_data == SYNC_BYTE)) begin
                    state_d = ST_LEN;
                    cnt_d   = '0;
                    sum_d   = '0;
                end
            end
            ST_LEN: begin
                if (xfer) begin
                    if (len_too_big) begin
                        state_d = ST_ERROR;
                    end else begin
                        len_d   = len_dec;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = cnt_q[ADDR_W-1:0];
                    ram_wdata_d = bus.rx_data;
                    sum_d       = chk_add(sum_q, bus.rx_data);
                    cnt_d       = cnt_q + ONE_L;
                    if (cnt_d == len_q) state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (xfer) state_d = (bus.rx_data == sum_q) ? ST_DONE : ST_ERROR;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERROR: begin
                if (start) state_d = ST_SYNC;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            sum_q       <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign bus.rx_ready  = rx_ready;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;

    // The CPU stays held through DONE and for as long as a failed load is parked in ERROR.
    assign cpu_hold   = (state_q != ST_IDLE);
    assign load_done  = (state_q == ST_DONE);
    assign load_error = (state_q == ST_ERROR);

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: directed frames, expected RAM writes and done/error events queued ahead.
module tb_ram_loader;

    localparam logic [1:0] K_WR   = 2'd0;
    localparam logic [1:0] K_DONE = 2'd1;
    localparam logic [1:0] K_ERR  = 2'd2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic cpu_hold, load_done, load_error;

    ram_loader_if #(.ADDR_W(4)) bus ();

    ram_loader #(.ADDR_W(4), .SYNC_BYTE(8'hA5)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [13:0] expq [$];
    logic [7:0]  txq [$];
    logic        err_prev = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic chk_ev(input logic [1:0] k, input logic [3:0] a, input logic [7:0] d);
        logic [13:0] e;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h, required nothing", k, a, d);
        end else begin
            e = expq.pop_front();
            if (e !== {k, a, d}) begin
                errors++;
                $display("FAIL event: got kind=%0d addr=%h data=%h, required kind=%0d addr=%h data=%h",
                         k, a, d, e[13:12], e[11:8], e[7:0]);
            end
        end
    endtask

    // Monitor: every write strobe, done pulse and rising error is matched against the queue.
    always @(negedge clk) begin
        if (bus.ram_we) chk_ev(K_WR, bus.ram_addr, bus.ram_wdata);
        if (load_done) chk_ev(K_DONE, 4'h0, 8'h00);
        if (load_error && !err_prev) chk_ev(K_ERR, 4'h0, 8'h00);
        err_prev <= load_error;
    end

    task automatic exp_wr(input logic [3:0] a, input logic [7:0] d);
        expq.push_back({K_WR, a, d});
    endtask

    task automatic exp_ev(input logic [1:0] k);
        expq.push_back({k, 4'h0, 8'h00});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        idle(1);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gappy);
        bit acc;
        int budget;
        if (gappy) begin
            bus.rx_valid = 1'b0;
            for (int g = 0; g < 6 && $urandom_range(2) != 0; g++) idle(1);
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        acc    = 1'b0;
        budget = 0;
        while (!acc && budget < 20) begin
            @(negedge clk);
            acc = bus.rx_ready;
            @(posedge clk);
            #1;
            budget++;
        end
        bus.rx_valid = 1'b0;
        check("byte_accepted", {31'd0, acc}, 32'd1);
    endtask

    task automatic send_frame(input bit gappy, input bit mid_start);
        for (int i = 0; i < txq.size(); i++) begin
            if (mid_start && i == 3) begin
                start = 1'b1;
                idle(1);
                start = 1'b0;
            end
            send_byte(txq[i], gappy);
        end
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        #12;
        check("reset_outputs", {15'd0, bus.rx_ready, bus.ram_we, load_done, load_error, cpu_hold,
                                bus.ram_addr, bus.ram_wdata}, 32'd0);
        reset = 1'b1;
        idle(3);
        check("idle_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        check("idle_cpu_hold", {31'd0, cpu_hold}, 32'd0);

        // Basic three-byte load, with a long rx_valid-low stall in SYNC
        do_start();
        check("hold_after_start", {31'd0, cpu_hold}, 32'd1);
        check("ready_in_sync", {31'd0, bus.rx_ready}, 32'd1);
        idle(10);
        check("ready_after_stall", {31'd0, bus.rx_ready}, 32'd1);
        exp_wr(4'h0, 8'h11); exp_wr(4'h1, 8'h22); exp_wr(4'h2, 8'h33); exp_ev(K_DONE);
        txq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        send_frame(1'b0, 1'b0);
        idle(2);
        check("hold_released", {31'd0, cpu_hold}, 32'd0);
        check("no_error", {31'd0, load_error}, 32'd0);

        // Checksum wraps to 01 against CHK 00: error, then recovery
        do_start();
        exp_wr(4'h0, 8'hFF); exp_wr(4'h1, 8'h02); exp_ev(K_ERR);
        txq = '{8'hA5, 8'h02, 8'hFF, 8'h02, 8'h00};
        send_frame(1'b0, 1'b0);
        idle(2);
        check("error_set", {31'd0, load_error}, 32'd1);
        check("hold_in_error", {31'd0, cpu_hold}, 32'd1);
        check("ready_in_error", {31'd0, bus.rx_ready}, 32'd0);
        do_start();
        check("error_cleared", {31'd0, load_error}, 32'd0);
        exp_wr(4'h0, 8'h11); exp_ev(K_DONE);
        txq = '{8'hA5, 8'h01, 8'h11, 8'h11};
        send_frame(1'b0, 1'b0);
        idle(2);
        check("hold_after_recovery", {31'd0, cpu_hold}, 32'd0);

        // Garbage before the sync marker is discarded
        do_start();
        exp_wr(4'h0, 8'h11); exp_ev(K_DONE);
        txq = '{8'h00, 8'h7E, 8'hA5, 8'h01, 8'h11, 8'h11};
        send_frame(1'b0, 1'b0);
        idle(2);

        // LEN 0 means full depth: 16 writes 0..F, sum 0x78
        do_start();
        txq = '{8'hA5, 8'h00};
        for (int i = 0; i < 16; i++) begin
            exp_wr(4'(i), 8'(i));
            txq.push_back(8'(i));
        end
        txq.push_back(8'h78);
        exp_ev(K_DONE);
        send_frame(1'b0, 1'b0);
        idle(2);
        check("hold_after_full", {31'd0, cpu_hold}, 32'd0);

        // LEN 0x11 exceeds depth: immediate error, no writes
        do_start();
        exp_ev(K_ERR);
        txq = '{8'hA5, 8'h11};
        send_frame(1'b0, 1'b0);
        idle(2);
        check("len_error", {31'd0, load_error}, 32'd1);

        // Sparse rx_valid and a start pulse mid-DATA leave the result unchanged
        do_start();
        check("error_cleared_2", {31'd0, load_error}, 32'd0);
        exp_wr(4'h0, 8'h11); exp_wr(4'h1, 8'h22); exp_wr(4'h2, 8'h33); exp_ev(K_DONE);
        txq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        send_frame(1'b1, 1'b1);
        idle(2);
        check("hold_after_gappy", {31'd0, cpu_hold}, 32'd0);

        // Asynchronous reset after the second data byte
        do_start();
        exp_wr(4'h0, 8'h11);
        txq = '{8'hA5, 8'h03, 8'h11, 8'h22};
        send_frame(1'b0, 1'b0);
        #1;
        reset = 1'b0;
        #1;
        check("async_reset_outputs", {15'd0, bus.rx_ready, bus.ram_we, load_done, load_error, cpu_hold,
                                      bus.ram_addr, bus.ram_wdata}, 32'd0);
        idle(1);
        reset = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hA5;
        idle(5);
        check("no_activity_ready", {31'd0, bus.rx_ready}, 32'd0);
        check("no_activity_hold", {31'd0, cpu_hold}, 32'd0);
        bus.rx_valid = 1'b0;

        do_start();
        exp_wr(4'h0, 8'h11); exp_ev(K_DONE);
        txq = '{8'hA5, 8'h01, 8'h11, 8'h11};
        send_frame(1'b0, 1'b0);
        idle(3);
        check("scoreboard_drained", expq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
